display_raster_reader: RTL and testbench

Receiving end of the display evaluator output. Captures one full `pix` frame (WIDTH*HEIGHT bits) from the evaluated display circuit through a valid/ready handshake. Streams it out in raster order as 8-pixel beats with row/column coordinates, so the frame can be pushed to a panel driver or a host FIFO. The capture register is the only place the frame is held, so the circuit output can change as soon as a frame is accepted.

---
 rtl/display_raster_reader.sv | 188 ++++++++++++++++++
 tb/tb_display_raster_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_raster_reader.sv
// Captures one WIDTH*HEIGHT frame and replays it as raster-ordered 8-pixel beats.
// Define DISPLAY_RASTER_DOUBLE_BUFFER_EN to add a shadow frame buffer.
module display_raster_reader #(
    parameter int WIDTH  = 120,
    parameter int HEIGHT = 52,
    localparam int NCOL  = WIDTH / 8,
    localparam int COLW  = (NCOL > 1) ? $clog2(NCOL) : 1,
    localparam int ROWW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_valid,
    output logic                    frame_ready,
    input  logic [WIDTH*HEIGHT-1:0] pix,
    output logic                    px_valid,
    input  logic                    px_ready,
    output logic [7:0]              px_data,
    output logic [COLW-1:0]         px_col,
    output logic [ROWW-1:0]         px_row,
    output logic                    px_sol,
    output logic                    px_eof
);

    localparam int BEATS = NCOL * HEIGHT;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t          state_q, state_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic [7:0]      data_q, data_d;
    logic [COLW-1:0] col_q, col_d;
    logic [ROWW-1:0] row_q, row_d;
    logic [BW-1:0]   bidx_q, bidx_d;
    logic            sol_q, sol_d;
    logic            eof_q, eof_d;
    logic [7:0]      cap_q [BEATS];
    logic            accept, xfer, ld_pix;

`ifdef DISPLAY_RASTER_DOUBLE_BUFFER_EN
    logic [7:0]      sh_q [BEATS];
    logic            sh_full_q, sh_full_d;
    logic            ld_sh, wr_sh;
`endif

    assign accept = frame_valid && ready_q;
    assign xfer   = valid_q && px_ready;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        col_d   = col_q;
        row_d   = row_q;
        bidx_d  = bidx_q;
        sol_d   = sol_q;
        eof_d   = eof_q;
        ld_pix  = 1'b0;
`ifdef DISPLAY_RASTER_DOUBLE_BUFFER_EN
        sh_full_d = sh_full_q;
        ld_sh     = 1'b0;
        wr_sh     = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef DISPLAY_RASTER_DOUBLE_BUFFER_EN
                // A frame parked while the last eof retired starts here.
                if (sh_full_q) ld_sh = 1'b1;
                else if (accept) ld_pix = 1'b1;
`else
                if (accept) ld_pix = 1'b1;
`endif
            end
            STREAM: begin
`ifdef DISPLAY_RASTER_DOUBLE_BUFFER_EN
                if (accept) wr_sh = 1'b1;
`endif
                if (xfer) begin
                    if (eof_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        col_d   = '0;
                        row_d   = '0;
                        bidx_d  = '0;
                        sol_d   = 1'b0;
                        eof_d   = 1'b0;
`ifdef DISPLAY_RASTER_DOUBLE_BUFFER_EN
                        if (sh_full_q) ld_sh = 1'b1;
`endif
                    end else begin
                        if (col_q == COLW'(NCOL - 1)) begin
                            col_d = '0;
                            row_d = row_q + ROWW'(1);
                        end else begin
                            col_d = col_q + COLW'(1);
                        end
                        bidx_d = bidx_q + BW'(1);
                        data_d = cap_q[bidx_d];
                        sol_d  = (col_d == '0);
                        eof_d  = (col_d == COLW'(NCOL - 1)) &&
                                 (row_d == ROWW'(HEIGHT - 1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef DISPLAY_RASTER_DOUBLE_BUFFER_EN
        if (ld_pix || ld_sh) begin
`else
        if (ld_pix) begin
`endif
            state_d = STREAM;
            valid_d = 1'b1;
            col_d   = '0;
            row_d   = '0;
            bidx_d  = '0;
            sol_d   = 1'b1;
            eof_d   = (BEATS == 1);
            data_d  = pix[7:0];
`ifdef DISPLAY_RASTER_DOUBLE_BUFFER_EN
            if (ld_sh) data_d = sh_q[0];
`endif
        end

`ifdef DISPLAY_RASTER_DOUBLE_BUFFER_EN
        if (ld_sh) sh_full_d = 1'b0;
        if (wr_sh) sh_full_d = 1'b1;
        ready_d = !sh_full_d;
`else
        ready_d = (state_d == IDLE);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            bidx_q  <= '0;
            sol_q   <= 1'b0;
            eof_q   <= 1'b0;
`ifdef DISPLAY_RASTER_DOUBLE_BUFFER_EN
            sh_full_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            col_q   <= col_d;
            row_q   <= row_d;
            bidx_q  <= bidx_d;
            sol_q   <= sol_d;
            eof_q   <= eof_d;
`ifdef DISPLAY_RASTER_DOUBLE_BUFFER_EN
            sh_full_q <= sh_full_d;
`endif
        end
    end

    // Frame storage carries no reset; its content is dead outside STREAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BEATS; i++) begin
            if (ld_pix) cap_q[i] <= pix[8*i +: 8];
`ifdef DISPLAY_RASTER_DOUBLE_BUFFER_EN
            if (ld_sh) cap_q[i] <= sh_q[i];
            if (wr_sh) sh_q[i] <= pix[8*i +: 8];
`endif
        end
    end

    assign frame_ready = ready_q;
    assign px_valid    = valid_q;
    assign px_data     = data_q;
    assign px_col      = col_q;
    assign px_row      = row_q;
    assign px_sol      = sol_q;
    assign px_eof      = eof_q;

endmodule

// File: tb/tb_display_raster_reader.sv
// Bench for display_raster_reader: small 16x2 and default 120x52 instances.
// Expected beats come from the raster rule pixel(x,y) = pix[y*WIDTH+x].
module tb_display_raster_reader;

    localparam int DW = 120;
    localparam int DH = 52;
    localparam int DB = DW * DH / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        s_fv, s_fr, s_pv, s_pr, s_sol, s_eof;
    logic [31:0] s_pix;
    logic [7:0]  s_data;
    logic [0:0]  s_col, s_row;

    logic            d_fv, d_fr, d_pv, d_pr, d_sol, d_eof;
    logic [DW*DH-1:0] d_pix, d_exp, d_reas;
    logic [7:0]      d_data;
    logic [3:0]      d_col;
    logic [5:0]      d_row;

    int errs = 0;
    int checks = 0;

    display_raster_reader #(.WIDTH(16), .HEIGHT(2)) u_small (
        .clk(clk), .rst_n(rst_n),
        .frame_valid(s_fv), .frame_ready(s_fr), .pix(s_pix),
        .px_valid(s_pv), .px_ready(s_pr), .px_data(s_data),
        .px_col(s_col), .px_row(s_row), .px_sol(s_sol), .px_eof(s_eof)
    );

    display_raster_reader u_dflt (
        .clk(clk), .rst_n(rst_n),
        .frame_valid(d_fv), .frame_ready(d_fr), .pix(d_pix),
        .px_valid(d_pv), .px_ready(d_pr), .px_data(d_data),
        .px_col(d_col), .px_row(d_row), .px_sol(d_sol), .px_eof(d_eof)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_small_ready();
        int w;
        w = 0;
        while (!s_fr && w < 20) begin
            tick();
            w++;
        end
        chk("s_ready_wait", s_fr, 1);
    endtask

    task automatic check_small_beat(input logic [63:0] fr, input int k);
        chk("s_valid", s_pv, 1);
        chk("s_data", s_data, fr[8*k +: 8]);
        chk("s_col", s_col, k % 2);
        chk("s_row", s_row, (k / 2) % 2);
        chk("s_sol", s_sol, (k % 2) == 0);
        chk("s_eof", s_eof, (k % 4) == 3);
    endtask

    // mode 0: px_ready high; mode 1: px_ready pattern 1,0,0,1,0,0,...
    task automatic run_small(input logic [31:0] p, input int mode);
        int k, cyc;
        logic [63:0] fr;
        fr = {32'h0, p};
        wait_small_ready();
        s_fv = 1'b1;
        s_pix = p;
        tick();
        s_fv = 1'b0;
        s_pix = $urandom;
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 40) begin
            s_pr = (mode == 0) || (cyc % 3 == 0);
            check_small_beat(fr, k);
`ifndef DISPLAY_RASTER_DOUBLE_BUFFER_EN
            chk("s_ready_stream", s_fr, 0);
`endif
            tick();
            if (s_pr) k++;
            cyc++;
        end
        chk("s_beats", k, 4);
        chk("s_idle_valid", s_pv, 0);
        chk("s_idle_ready", s_fr, 1);
    endtask

    initial begin
        int k, cyc, neof;
        logic [31:0] fa;
        rst_n = 1'b0;
        s_fv = 1'b1;
        d_fv = 1'b1;
        s_pr = 1'b1;
        d_pr = 1'b1;
        s_pix = $urandom;
        for (int i = 0; i < DW * DH / 32; i++) d_pix[32*i +: 32] = $urandom;
        repeat (3) tick();
        chk("rst_ready", s_fr, 0);
        chk("rst_valid", s_pv, 0);
        chk("rst_data", s_data, 0);
        chk("rst_col", s_col, 0);
        chk("rst_row", s_row, 0);
        chk("rst_sol", s_sol, 0);
        chk("rst_eof", s_eof, 0);
        chk("rst_d_ready", d_fr, 0);
        chk("rst_d_valid", d_pv, 0);
        chk("rst_d_data", d_data, 0);
        rst_n = 1'b1;
        s_fv = 1'b0;
        d_fv = 1'b0;
        chk("rel_ready_pre", s_fr, 0);
        tick();
        chk("rel_ready_post", s_fr, 1);
        chk("rel_d_ready_post", d_fr, 1);

        run_small(32'hA55A_F00F, 0);
        run_small(32'hA55A_F00F, 1);
        for (int r = 0; r < 3; r++) run_small($urandom, r % 2);

        // Default geometry, random frame, pix scrambled after accept.
        for (int i = 0; i < DW * DH / 32; i++) d_pix[32*i +: 32] = $urandom;
        d_exp = d_pix;
        d_reas = '0;
        d_fv = 1'b1;
        tick();
        d_fv = 1'b0;
        for (int i = 0; i < DW * DH / 32; i++) d_pix[32*i +: 32] = $urandom;
        k = 0;
        cyc = 0;
        neof = 0;
        while (k < DB && cyc < 1000) begin
            chk("d_valid", d_pv, 1);
            chk("d_data", d_data, d_exp[8*k +: 8]);
            chk("d_col", d_col, k % (DW / 8));
            chk("d_row", d_row, k / (DW / 8));
            chk("d_sol", d_sol, (k % (DW / 8)) == 0);
            chk("d_eof", d_eof, k == DB - 1);
            d_reas[8*k +: 8] = d_data;
            if (d_eof) neof++;
            tick();
            k++;
            cyc++;
        end
        chk("d_beats", k, DB);
        chk("d_eof_count", neof, 1);
        checks++;
        assert (d_reas === d_exp) else begin
            errs++;
            $error("FAIL d_reassembled observed=%0h expected=%0h",
                   d_reas[63:0], d_exp[63:0]);
        end
        chk("d_idle_valid", d_pv, 0);
        chk("d_idle_ready", d_fr, 1);

        // Reset mid-frame after two beats have transferred.
        fa = $urandom;
        wait_small_ready();
        s_pr = 1'b1;
        s_fv = 1'b1;
        s_pix = fa;
        tick();
        s_fv = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_small_beat({32'h0, fa}, i);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", s_pv, 0);
        chk("mid_rst_eof", s_eof, 0);
        chk("mid_rst_ready", s_fr, 0);
        tick();
        rst_n = 1'b1;
        run_small(32'h1234_5678, 0);

`ifdef DISPLAY_RASTER_DOUBLE_BUFFER_EN
        begin
            logic [63:0] ab;
            ab = {32'h0BAD_CAFE, 32'hDEAD_BEEF};
            wait_small_ready();
            s_pr = 1'b1;
            s_fv = 1'b1;
            s_pix = ab[31:0];
            tick();
            k = 0;
            cyc = 0;
            while (k < 8 && cyc < 20) begin
                check_small_beat(ab, k);
                if (k == 0) begin
                    chk("db_ready_shadow", s_fr, 1);
                    s_fv = 1'b1;
                    s_pix = ab[63:32];
                end else if (k < 4) begin
                    chk("db_ready_full", s_fr, 0);
                    s_fv = 1'b1;
                    s_pix = $urandom;
                end else if (k == 4) begin
                    chk("db_ready_free", s_fr, 1);
                    s_fv = 1'b0;
                end
                tick();
                k++;
                cyc++;
            end
            chk("db_beats", k, 8);
            chk("db_idle_valid", s_pv, 0);
            chk("db_idle_ready", s_fr, 1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
